// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback/mult-div/exception and drives datapath strobes.
// FETCH/MEM stretch to MEM_LAT cycles and MULDIV_WAIT to MULDIV_CYCLES using one shared wait counter.
module controle_multiciclo #(
  parameter int MEM_LAT       = 1,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       div_zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic       muldiv_start,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] cause,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    S_START = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3,
    S_MEM = 4'd4, S_WB = 4'd5, S_MDW = 4'd6, S_EXC = 4'd7
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_MULT, C_DIV, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_INV
  } cls_t;

  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MULDIV_CYCLES - 1);

  state_t           r_state, w_next;
  cls_t             r_cls, w_dec;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause, w_exc_cause;
  logic             w_add_fam;

  always_comb begin
    w_dec = C_INV;
    case (OP)
      6'h00:   w_dec = (funct == 6'h18) ? C_MULT : (funct == 6'h1A) ? C_DIV : C_RALU;
      6'h08:   w_dec = C_ADDI;
      6'h23:   w_dec = C_LW;
      6'h2B:   w_dec = C_SW;
      6'h04:   w_dec = C_BEQ;
      6'h02:   w_dec = C_J;
      default: w_dec = C_INV;
    endcase
  end

  // Only the trapping add/sub functs can raise an overflow exception.
  assign w_add_fam = (funct == 6'h20) || (funct == 6'h22);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_cls   <= C_INV;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state) ? r_cnt + 1'b1 : '0;
      if (r_state == S_DECODE) r_cls <= w_dec;
      if (w_next == S_EXC) r_cause <= w_exc_cause;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_exc_cause = 2'b00;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  if (r_cnt == MEM_LAST) w_next = S_DECODE;
      S_DECODE: begin
        w_next      = (w_dec == C_INV) ? S_EXC : S_EXEC;
        w_exc_cause = 2'b01;
      end
      S_EXEC: begin
        case (r_cls)
          C_RALU: begin
            w_next      = (w_add_fam && overflow) ? S_EXC : S_WB;
            w_exc_cause = 2'b10;
          end
          C_ADDI: begin
            w_next      = overflow ? S_EXC : S_WB;
            w_exc_cause = 2'b10;
          end
          C_LW, C_SW: w_next = S_MEM;
          C_MULT:     w_next = S_MDW;
          C_DIV: begin
            w_next      = div_zero ? S_EXC : S_MDW;
            w_exc_cause = 2'b11;
          end
          default:    w_next = S_FETCH;
        endcase
      end
      S_MEM:    if (r_cnt == MEM_LAST) w_next = (r_cls == C_LW) ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_MDW:    if (r_cnt == MD_LAST) w_next = S_FETCH;
      S_EXC:    w_next = S_FETCH;
      default:  w_next = S_START;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    epc_write    = 1'b0;
    muldiv_start = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    pc_src       = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    alu_src_a    = 1'b0;
    cause        = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (r_cnt == MEM_LAST) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXEC: begin
        case (r_cls)
          C_RALU: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
          end
          C_ADDI, C_LW, C_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
          end
          C_BEQ: begin
            alu_op   = 2'b01;
            pc_src   = 2'b01;
            pc_write = zero;
          end
          C_J: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
          end
          C_MULT, C_DIV: muldiv_start = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read  = (r_cls == C_LW);
        mem_write = (r_cls == C_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_cls == C_LW);
        reg_dst    = (r_cls == C_RALU);
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = 2'b11;
        cause     = r_cause;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;
endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction expected cycle traces built from the instruction rules.
module tb_controle_multiciclo;
  localparam int ML = 3;
  localparam int MD = 4;

  // State numbering follows the order in which the states are listed for the block.
  localparam logic [3:0] ST_START = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3,
                         ST_MEM = 4'd4, ST_WB = 4'd5, ST_MDW = 4'd6, ST_EXC = 4'd7;
  localparam int K_RALU = 0, K_MULT = 1, K_DIV = 2, K_ADDI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_J = 7, K_INV = 8;

  typedef struct packed {
    logic [3:0] st;
    logic pc_write, ir_write, mem_read, mem_write, reg_write, epc_write, muldiv_start, mem_to_reg, reg_dst;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic alu_src_a;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   exec;
  } cyc_t;

  logic clk, reset;
  logic [5:0] OP, funct;
  logic zero, overflow, div_zero;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, epc_write, muldiv_start, mem_to_reg, reg_dst;
  logic [1:0] pc_src, alu_src_b, alu_op, cause;
  logic alu_src_a;
  logic [3:0] state_o;

  vec_t obs;
  assign obs = {state_o, pc_write, ir_write, mem_read, mem_write, reg_write, epc_write, muldiv_start,
                mem_to_reg, reg_dst, pc_src, alu_src_b, alu_op, alu_src_a, cause};

  controle_multiciclo #(.MEM_LAT(ML), .MULDIV_CYCLES(MD), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .OP(OP), .funct(funct),
    .zero(zero), .overflow(overflow), .div_zero(div_zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .epc_write(epc_write), .muldiv_start(muldiv_start),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .cause(cause), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  cyc_t q[$];

  task automatic check(input string tag, input vec_t want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  function automatic vec_t mk(input logic [3:0] st);
    vec_t v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h18) ? K_MULT : (fn == 6'h1A) ? K_DIV : K_RALU;
      6'h08:   return K_ADDI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return K_INV;
    endcase
  endfunction

  task automatic push(input vec_t v, input bit ex);
    cyc_t c;
    c.v = v;
    c.exec = ex;
    q.push_back(c);
  endtask

  task automatic push_exc(input logic [1:0] c);
    vec_t v = mk(ST_EXC);
    v.epc_write = 1'b1;
    v.pc_write  = 1'b1;
    v.pc_src    = 2'b11;
    v.cause     = c;
    push(v, 1'b0);
  endtask

  task automatic push_wb(input bit lw, input bit rt);
    vec_t v = mk(ST_WB);
    v.reg_write  = 1'b1;
    v.mem_to_reg = lw;
    v.reg_dst    = rt;
    push(v, 1'b0);
  endtask

  // Expected cycle trace from the FETCH of this instruction up to, not including, the next FETCH.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit ov, input bit dz);
    vec_t v;
    int k = classify(op, fn);
    q.delete();
    for (int i = 0; i < ML; i++) begin
      v = mk(ST_FETCH);
      v.mem_read = 1'b1;
      if (i == ML - 1) begin
        v.ir_write  = 1'b1;
        v.pc_write  = 1'b1;
        v.alu_src_b = 2'b01;
      end
      push(v, 1'b0);
    end
    v = mk(ST_DECODE);
    v.alu_src_b = 2'b11;
    push(v, 1'b0);
    if (k == K_INV) begin
      push_exc(2'b01);
      return;
    end
    v = mk(ST_EXEC);
    case (k)
      K_RALU: begin
        v.alu_src_a = 1'b1;
        v.alu_op    = 2'b10;
        push(v, 1'b1);
        if ((fn == 6'h20 || fn == 6'h22) && ov) push_exc(2'b10);
        else push_wb(1'b0, 1'b1);
      end
      K_ADDI, K_LW, K_SW: begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = 2'b10;
        push(v, 1'b1);
        if (k == K_ADDI) begin
          if (ov) push_exc(2'b10);
          else push_wb(1'b0, 1'b0);
        end else begin
          for (int i = 0; i < ML; i++) begin
            v = mk(ST_MEM);
            v.mem_read  = (k == K_LW);
            v.mem_write = (k == K_SW);
            push(v, 1'b0);
          end
          if (k == K_LW) push_wb(1'b1, 1'b0);
        end
      end
      K_BEQ: begin
        v.alu_op   = 2'b01;
        v.pc_src   = 2'b01;
        v.pc_write = z;
        push(v, 1'b1);
      end
      K_J: begin
        v.pc_src   = 2'b10;
        v.pc_write = 1'b1;
        push(v, 1'b1);
      end
      default: begin
        v.muldiv_start = 1'b1;
        push(v, 1'b1);
        if (k == K_DIV && dz) push_exc(2'b11);
        else for (int i = 0; i < MD; i++) push(mk(ST_MDW), 1'b0);
      end
    endcase
  endtask

  task automatic rand_flags();
    zero     = 1'($urandom);
    overflow = 1'($urandom);
    div_zero = 1'($urandom);
  endtask

  // Entered #1 after a rising edge with the DUT in FETCH; leaves it the same way.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input bit z, input bit ov, input bit dz, input int abort_at);
    model(op, fn, z, ov, dz);
    OP    = op;
    funct = fn;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].exec) begin
        zero     = z;
        overflow = ov;
        div_zero = dz;
      end else rand_flags();
      #2;
      check($sformatf("%s_c%0d", tag, i), q[i].v);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_abort", tag), mk(ST_START));
        @(posedge clk);
        #1;
        check($sformatf("%s_held", tag), mk(ST_START));
        reset = 1'b1;
        #1;
        check($sformatf("%s_start", tag), mk(ST_START));
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] rfn [8];
    logic [5:0] op, fn;
    bit ov;
    ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    rfn = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A};
    reset = 1'b0;
    OP = 6'h00;
    funct = 6'h00;
    rand_flags();
    #2;
    check("reset_async", mk(ST_START));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rand_flags();
      #1;
      check("reset_hold", mk(ST_START));
    end
    reset = 1'b1;
    #1;
    check("start_cycle", mk(ST_START));
    @(posedge clk);
    #1;

    run("lw",       6'h23, 6'h00, 0, 0, 0, -1);
    run("beq_z1",   6'h04, 6'h00, 1, 0, 0, -1);
    run("beq_z0",   6'h04, 6'h00, 0, 0, 0, -1);
    run("add_ovf",  6'h00, 6'h20, 0, 1, 0, -1);
    run("add",      6'h00, 6'h20, 0, 0, 0, -1);
    run("div",      6'h00, 6'h1A, 0, 0, 0, -1);
    run("div_zero", 6'h00, 6'h1A, 0, 0, 1, -1);
    run("mult",     6'h00, 6'h18, 0, 1, 1, -1);
    run("invalid",  6'h3F, 6'h00, 1, 1, 1, -1);
    run("j",        6'h02, 6'h00, 0, 0, 0, -1);
    run("addi",     6'h08, 6'h00, 0, 0, 0, -1);
    run("addi_ovf", 6'h08, 6'h00, 0, 1, 0, -1);
    run("sw",       6'h2B, 6'h00, 0, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(7)];
      if (op == 6'h3F) op = 6'($urandom);
      fn = (op == 6'h00) ? rfn[$urandom_range(7)] : 6'($urandom);
      ov = 1'($urandom);
      if (op == 6'h00 && fn != 6'h20) ov = 1'b0;
      run($sformatf("rnd%0d", n), op, fn, 1'($urandom), ov, 1'($urandom), -1);
    end

    // Third MEM cycle of SW is trace index ML + 1 + 1 + 2.
    run("sw_rst",   6'h2B, 6'h00, 0, 0, 0, ML + 4);
    run("lw_after", 6'h23, 6'h00, 0, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameter MEM_LAT, default 1: memory access latency in cycles, legal range 1..2^CNT_W-1.
REQ-002 Parameter MULDIV_CYCLES, default 32: mult/div busy cycles, legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 6: width of the internal wait counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 OP  in  6  instruction opcode; funct  in  6  R-type function field.
REQ-008 zero, overflow, div_zero  in  1 each  ALU/divider status flags, valid during EXEC.
REQ-009 pc_write, ir_write, mem_read, mem_write, reg_write, epc_write, muldiv_start, mem_to_reg, reg_dst  out  1 each.
REQ-010 pc_src  out  2: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = exception vector.
REQ-011 alu_src_b  out  2; alu_op  out  2 (00 add, 01 sub, 10 funct); alu_src_a  out  1; cause  out  2 (00 none, 01 invalid op, 10 overflow, 11 div-by-zero).
REQ-012 state_o  out  4: current state encoding, debug only.

Function
REQ-013 States SHALL be START, FETCH, DECODE, EXEC, MEM, WB, MULDIV_WAIT, EXC; every output is 0 unless listed for the current state.
REQ-014 Instruction class SHALL be latched in DECODE: R-ALU (OP=0, funct not 0x18/0x1A), MULT (OP=0, funct 0x18), DIV (OP=0, funct 0x1A), ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02; anything else is INVALID.
REQ-015 START lasts exactly one cycle, then goes to FETCH.
REQ-016 FETCH lasts MEM_LAT cycles with mem_read=1 throughout; in its final cycle ir_write=1, pc_write=1, pc_src=00, alu_src_b=01, alu_op=00.
REQ-017 DECODE lasts one cycle with alu_src_b=11 (branch target precompute); INVALID goes to EXC with cause=01, all others go to EXEC.
REQ-018 EXEC: R-ALU uses alu_src_a=1, alu_op=10; an add-family funct with overflow=1 goes to EXC (cause 10); otherwise it goes to WB.
REQ-019 EXEC for ADDI/LW/SW uses alu_src_a=1, alu_src_b=10, alu_op=00; ADDI overflow goes to EXC (cause 10); LW/SW go to MEM, ADDI to WB.
REQ-020 EXEC for BEQ: alu_op=01, pc_src=01, pc_write=zero (combinational), then FETCH; J: pc_src=10, pc_write=1, then FETCH.
REQ-021 EXEC for MULT/DIV: muldiv_start=1 for one cycle; DIV with div_zero=1 goes to EXC (cause 11); otherwise MULDIV_WAIT.
REQ-022 MULDIV_WAIT lasts exactly MULDIV_CYCLES cycles, then FETCH; no outputs asserted.
REQ-023 MEM lasts MEM_LAT cycles with mem_read=1 (LW) or mem_write=1 (SW) for every cycle; LW then goes to WB, SW to FETCH.
REQ-024 WB lasts one cycle with reg_write=1; mem_to_reg=1 for LW; reg_dst=1 for R-ALU; then FETCH.
REQ-025 EXC lasts one cycle with epc_write=1, pc_write=1, pc_src=11, cause held; then FETCH.
REQ-026 The wait counter SHALL load 0 on entry to any multi-cycle state, increment each cycle, and exit at count = LAT-1; it never wraps.
REQ-027 With MEM_LAT=1, FETCH and MEM SHALL be single-cycle, with final-cycle outputs asserted in that cycle.
REQ-028 Flags sampled outside EXEC SHALL have no effect.

Reset
REQ-029 While reset=0, state SHALL be START, the counter 0, the latched class INVALID, and every output 0, independent of clk.
REQ-030 Reset asserted mid-operation (any state, any count) SHALL abort immediately; memory/register write strobes drop the same instant.
REQ-031 After reset rises, the first rising edge SHALL enter FETCH (START visible one cycle).

Verification
REQ-032 MEM_LAT=3, LW: state sequence START, FETCH x3, DECODE, EXEC, MEM x3, WB, FETCH; ir_write only in FETCH cycle 3; reg_write=1, mem_to_reg=1 in WB.
REQ-033 BEQ with zero=1 in EXEC -> pc_write=1, pc_src=01 for one cycle; the same case with zero=0 -> pc_write=0, next state FETCH.
REQ-034 OP=0, funct=0x20, overflow=1 in EXEC -> EXC next with epc_write=1, pc_src=11, cause=10, then FETCH; reg_write is never asserted.
REQ-035 DIV with div_zero=0 and MULDIV_CYCLES=4 -> muldiv_start one cycle, MULDIV_WAIT exactly 4 cycles, then FETCH; with div_zero=1 -> EXC, cause=11.
REQ-036 OP=0x3F -> DECODE then EXC with cause=01; reset pulled low during the third MEM cycle of SW -> mem_write=0 immediately, state_o=START.
